// File: rtl/dff_pipeline.sv
// WIDTH x DEPTH register delay line with per-stage valid, stall (en), flush and a registered occupancy count.
// Define DFF_PIPE_PARITY_EN to carry an even-parity bit per stage and raise a sticky parity_err at the output.
module dff_pipeline #(
  parameter int               WIDTH     = 8,
  parameter int               DEPTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
  input  logic                       clock_100Mhz,
  input  logic                       reset,
  input  logic                       en,
  input  logic                       flush,
  input  logic [WIDTH-1:0]           d,
  input  logic                       d_valid,
  output logic [WIDTH-1:0]           q,
  output logic                       q_valid,
  output logic [$clog2(DEPTH+1)-1:0] occupancy,
  output logic                       busy,
  output logic                       parity_err
);

  localparam int OW = $clog2(DEPTH + 1);

  logic [DEPTH-1:0][WIDTH-1:0] data_q;
  logic [DEPTH-1:0]            vld_q;
  logic [OW-1:0]               occ_q;
  logic [OW-1:0]               occ_d;
  logic                        busy_q;

  // One word enters and the oldest leaves on every advance, so the count moves by at most one.
  always_comb begin
    occ_d = occ_q + OW'(d_valid) - OW'(vld_q[DEPTH-1]);
  end

  always_ff @(posedge clock_100Mhz) begin
    if (reset || flush) begin
      data_q <= {DEPTH{RESET_VAL}};
      vld_q  <= '0;
      occ_q  <= '0;
      busy_q <= 1'b0;
    end else if (en) begin
      data_q[0] <= d;
      vld_q[0]  <= d_valid;
      for (int i = 1; i < DEPTH; i++) begin
        data_q[i] <= data_q[i-1];
        vld_q[i]  <= vld_q[i-1];
      end
      occ_q  <= occ_d;
      busy_q <= (occ_d != '0);
    end
  end

  assign q         = data_q[DEPTH-1];
  assign q_valid   = vld_q[DEPTH-1];
  assign occupancy = occ_q;
  assign busy      = busy_q;

`ifdef DFF_PIPE_PARITY_EN
  logic [DEPTH-1:0] par_q;
  logic             perr_q;

  always_ff @(posedge clock_100Mhz) begin
    if (reset || flush) begin
      par_q <= '0;
    end else if (en) begin
      par_q[0] <= ^d;
      for (int i = 1; i < DEPTH; i++) begin
        par_q[i] <= par_q[i-1];
      end
    end
  end

  // Only flush-immune state in the block: cleared by reset alone.
  always_ff @(posedge clock_100Mhz) begin
    if (reset) begin
      perr_q <= 1'b0;
    end else if (vld_q[DEPTH-1] && ((^data_q[DEPTH-1]) != par_q[DEPTH-1])) begin
      perr_q <= 1'b1;
    end
  end

  assign parity_err = perr_q;
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_dff_pipeline.sv
// Directed bench for dff_pipeline (WIDTH=8, DEPTH=4): reset, latency/ordering, stall, flush, reset priority, parity.
module tb_dff_pipeline;

  logic       clk;
  logic       reset;
  logic       en;
  logic       flush;
  logic [7:0] d;
  logic       d_valid;
  logic [7:0] q;
  logic       q_valid;
  logic [2:0] occupancy;
  logic       busy;
  logic       parity_err;

  int n_asrt = 0;
  int n_fail = 0;

  dff_pipeline #(.WIDTH(8), .DEPTH(4), .RESET_VAL(8'h00)) dut (
    .clock_100Mhz (clk),
    .reset        (reset),
    .en           (en),
    .flush        (flush),
    .d            (d),
    .d_valid      (d_valid),
    .q            (q),
    .q_valid      (q_valid),
    .occupancy    (occupancy),
    .busy         (busy),
    .parity_err   (parity_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // check_q=0 skips q where the stage holds a stale word the consumer must ignore.
  task automatic check(input string tag, input logic [7:0] eq, input logic check_q,
                       input logic eqv, input logic [2:0] eocc, input logic eb, input logic eperr);
    if (check_q) begin
      n_asrt++;
      assert (q === eq) else begin
        n_fail++;
        $error("FAIL %s q: observed %0h expected %0h", tag, q, eq);
      end
    end
    n_asrt++;
    assert (q_valid === eqv) else begin
      n_fail++;
      $error("FAIL %s q_valid: observed %0b expected %0b", tag, q_valid, eqv);
    end
    n_asrt++;
    assert (occupancy === eocc) else begin
      n_fail++;
      $error("FAIL %s occupancy: observed %0d expected %0d", tag, occupancy, eocc);
    end
    n_asrt++;
    assert (busy === eb) else begin
      n_fail++;
      $error("FAIL %s busy: observed %0b expected %0b", tag, busy, eb);
    end
    n_asrt++;
    assert (parity_err === eperr) else begin
      n_fail++;
      $error("FAIL %s parity_err: observed %0b expected %0b", tag, parity_err, eperr);
    end
  endtask

  initial begin
    reset = 1'b1; en = 1'b1; flush = 1'b0; d = 8'hFF; d_valid = 1'b1;
    #2;

    // Reset held two edges while en/d_valid are active.
    step();
    step();
    check("reset", 8'h00, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0);

    // Latency and ordering: A1,B2,C3 then invalid words.
    reset = 1'b0;
    d = 8'hA1; d_valid = 1'b1; step(); check("lat_in1", 8'h00, 1'b1, 1'b0, 3'd1, 1'b1, 1'b0);
    d = 8'hB2;                 step(); check("lat_in2", 8'h00, 1'b1, 1'b0, 3'd2, 1'b1, 1'b0);
    d = 8'hC3;                 step(); check("lat_in3", 8'h00, 1'b1, 1'b0, 3'd3, 1'b1, 1'b0);
    d = 8'h00; d_valid = 1'b0;
    step(); check("lat_out_a1", 8'hA1, 1'b1, 1'b1, 3'd3, 1'b1, 1'b0);
    step(); check("lat_out_b2", 8'hB2, 1'b1, 1'b1, 3'd2, 1'b1, 1'b0);
    step(); check("lat_out_c3", 8'hC3, 1'b1, 1'b1, 3'd1, 1'b1, 1'b0);
    step(); check("lat_drain",  8'h00, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);

    // Stall: fill all four stages, then hold with en=0 for five edges.
    d_valid = 1'b1;
    d = 8'h11; step();
    d = 8'h22; step();
    d = 8'h33; step();
    d = 8'h44; step(); check("stall_full", 8'h11, 1'b1, 1'b1, 3'd4, 1'b1, 1'b0);
    en = 1'b0; d = 8'h55; d_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step(); check($sformatf("stall_hold%0d", k), 8'h11, 1'b1, 1'b1, 3'd4, 1'b1, 1'b0);
    end
    en = 1'b1; d = 8'h00; d_valid = 1'b0;
    step(); check("stall_res22", 8'h22, 1'b1, 1'b1, 3'd3, 1'b1, 1'b0);
    step(); check("stall_res33", 8'h33, 1'b1, 1'b1, 3'd2, 1'b1, 1'b0);
    step(); check("stall_res44", 8'h44, 1'b1, 1'b1, 3'd1, 1'b1, 1'b0);
    step(); check("stall_empty", 8'h00, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);

    // Flush beats en: 8'h77 presented alongside flush must be dropped.
    d_valid = 1'b1;
    d = 8'h61; step();
    d = 8'h62; step();
    d = 8'h63; step(); check("flush_pre", 8'h00, 1'b0, 1'b0, 3'd3, 1'b1, 1'b0);
    flush = 1'b1; d = 8'h77; d_valid = 1'b1;
    step(); check("flush", 8'h00, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0);
    flush = 1'b0; d = 8'h00; d_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step(); check($sformatf("flush_after%0d", k), 8'h00, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0);
    end

    // Reset with flush asserted mid-operation: one edge restores everything.
    d_valid = 1'b1;
    d = 8'h81; step();
    d = 8'h82; step(); check("rst_mid_pre", 8'h00, 1'b0, 1'b0, 3'd2, 1'b1, 1'b0);
    reset = 1'b1; flush = 1'b1; d = 8'h99;
    step(); check("rst_mid", 8'h00, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0);
    reset = 1'b0; flush = 1'b0; d = 8'h00; d_valid = 1'b0;

`ifdef DFF_PIPE_PARITY_EN
    // Corrupt bit 0 of 8'h0F while it sits in stage 1; q then shows 8'h0E.
    d = 8'h0F; d_valid = 1'b1; step();
    d = 8'h00; d_valid = 1'b0; step();
    force dut.data_q[1][0] = 1'b0;
    step();
    release dut.data_q[1][0];
    step(); check("par_at_q", 8'h0E, 1'b1, 1'b1, 3'd1, 1'b1, 1'b0);
    step(); check("par_set",  8'h00, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1);
    flush = 1'b1; step(); flush = 1'b0;
    check("par_flush", 8'h00, 1'b1, 1'b0, 3'd0, 1'b0, 1'b1);
    reset = 1'b1; step(); reset = 1'b0;
    check("par_reset", 8'h00, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0);
`else
    // Without parity storage a word passing through must never raise parity_err.
    d = 8'h0F; d_valid = 1'b1; step();
    d = 8'h00; d_valid = 1'b0; step();
    step();
    step(); check("nopar_at_q", 8'h0F, 1'b1, 1'b1, 3'd1, 1'b1, 1'b0);
    step(); check("nopar_after", 8'h00, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule
